// File: rtl/irq_arb_pkg.sv
// -----------------------------------------------------------------------------
// irq_arb_pkg
//   Shared constants and helpers for the interrupt request arbiter slice.
//   N_REQ_DEF  : default number of request lines (highest index = highest prio)
//   CODE_W_DEF : default width of the issued index code
//   onehot_of  : decodes an index code into an N_REQ_DEF-bit one-hot vector
// -----------------------------------------------------------------------------
package irq_arb_pkg;

    localparam int N_REQ_DEF  = 8;
    localparam int CODE_W_DEF = 3;

    function automatic logic [N_REQ_DEF-1:0] onehot_of(input logic [CODE_W_DEF-1:0] code);
        logic [N_REQ_DEF-1:0] vec;
        vec = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/irq_pending_arbiter_prio_sel.sv
// -----------------------------------------------------------------------------
// prio_sel_n
//   Combinational highest-set-bit selector.
//   Ports:
//     vec  in   N_REQ    candidate vector
//     idx  out  CODE_W   index of the highest set bit (meaningless when any=0)
//     any  out  1        at least one bit of vec is set
// -----------------------------------------------------------------------------
import irq_arb_pkg::*;

module prio_sel_n #(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [N_REQ-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Ascending scan: the last set bit seen is the highest one, so it wins.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// -----------------------------------------------------------------------------
// irq_pending_arbiter
//   Captures single-cycle request pulses into sticky pending bits and issues
//   the index of the highest-priority pending line through a registered
//   valid/ready output stage. Each captured pulse is issued exactly once.
//   Ports:
//     clk          in   1        clock, rising edge
//     rst_n        in   1        synchronous active-low reset
//     req_in       in   N_REQ    request pulses (one cycle high = one event)
//     mask_in      in   N_REQ    1 = capture enabled for that line
//     code_out     out  CODE_W   issued index (registered)
//     code_valid   out  1        code_out holds an unconsumed grant
//     code_ready   in   1        consumer takes code_out when code_valid=1
//     pending_out  out  N_REQ    captured, not yet issued requests
//     overrun      out  1        pulse: a request hit an already-pending line
// -----------------------------------------------------------------------------
import irq_arb_pkg::*;

module irq_pending_arbiter #(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    input  logic [N_REQ-1:0]  mask_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [N_REQ-1:0]  pending_out,
    output logic              overrun
);

    generate
        if (CODE_W != $clog2(N_REQ)) begin : g_bad_code_w
            $error("irq_pending_arbiter: CODE_W must equal $clog2(N_REQ)");
        end
    endgenerate

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic [N_REQ-1:0]  cap;
    logic [N_REQ-1:0]  issue_onehot;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;
    logic              load;
    logic              issue;

    // Selection works on the registered pending vector only, so a request
    // never reaches the output register in the cycle it arrives.
    prio_sel_n #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_prio_sel (
        .vec (pending_q),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        cap          = req_in & mask_in;
        load         = !valid_q || code_ready;
        issue        = load && sel_any;
        issue_onehot = issue ? onehot_of(sel_idx) : '0;

        // A pulse on the line being issued this cycle is a fresh event, so
        // capture is OR-ed in after the clear.
        pending_d = (pending_q & ~issue_onehot) | cap;
        // Only a hit on a line that stays pending is a lost (duplicate) event.
        overrun_d = |(cap & pending_q & ~issue_onehot);

        code_d  = issue ? sel_idx : code_q;
        valid_d = load ? sel_any : valid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign pending_out = pending_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask_in;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] pending_out;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: a set of outstanding events per line plus the
    // presented grant.
    bit m_pend[8];
    int m_code;
    bit m_valid;
    bit m_ovr;
    int grants_seen;

    always #5 clk = ~clk;

    irq_pending_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask_in     (mask_in),
        .code_out    (code_out),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .pending_out (pending_out),
        .overrun     (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int model_pend_vec();
        int v = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) v |= (1 << i);
        return v;
    endfunction

    // Apply the edge with the inputs present before it, from the rules:
    // issue the highest outstanding line if the output slot is free or
    // being consumed, then record new events, flagging ones that collide
    // with a still-outstanding event on the same line.
    task automatic model_edge(input logic [7:0] r, input logic [7:0] m, input logic rd, input logic rn);
        int hi;
        if (!rn) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
            m_code = 0; m_valid = 0; m_ovr = 0;
            return;
        end
        hi = -1;
        for (int i = 7; i >= 0; i--) if (m_pend[i] && hi < 0) hi = i;
        if (!m_valid || rd) begin
            if (m_valid && rd) grants_seen++;
            if (hi >= 0) begin
                m_code = hi; m_valid = 1; m_pend[hi] = 0;
            end else begin
                m_valid = 0;
            end
        end
        m_ovr = 0;
        for (int i = 0; i < 8; i++) begin
            if (r[i] && m[i]) begin
                if (m_pend[i]) m_ovr = 1;
                m_pend[i] = 1;
            end
        end
    endtask

    // One transaction: drive inputs, clock, update model, compare everything.
    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd, input logic rn);
        req_in = r; mask_in = m; code_ready = rd; rst_n = rn;
        @(posedge clk);
        model_edge(r, m, rd, rn);
        #1;
        check("pending_out", int'(pending_out), model_pend_vec());
        check("code_valid",  int'(code_valid),  int'(m_valid));
        check("code_out",    int'(code_out),    m_code);
        check("overrun",     int'(overrun),     int'(m_ovr));
        $display("t=%0t rst_n=%0b req=%02h mask=%02h rdy=%0b -> pend=%02h valid=%0b code=%0d ovr=%0b",
                 $time, rn, r, m, rd, pending_out, code_valid, code_out, overrun);
    endtask

    initial begin
        grants_seen = 0;
        m_code = 0; m_valid = 0; m_ovr = 0;
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
        req_in = '0; mask_in = '0; code_ready = 1'b0; rst_n = 1'b0;

        // 1 Reset with all requests asserted
        step(8'hFF, 8'hFF, 1, 0);
        step(8'hFF, 8'hFF, 1, 0);
        step(8'h00, 8'hFF, 1, 1);
        check("rst_pending", int'(pending_out), 0);
        check("rst_valid",   int'(code_valid),  0);
        check("rst_overrun", int'(overrun),     0);

        // 2 Burst 0xA4 -> 7,5,2
        step(8'hA4, 8'hFF, 1, 1);
        check("burst_pend", int'(pending_out), 8'hA4);
        step(8'h00, 8'hFF, 1, 1);
        check("burst_c7", int'(code_out), 7);
        check("burst_v7", int'(code_valid), 1);
        step(8'h00, 8'hFF, 1, 1);
        check("burst_c5", int'(code_out), 5);
        step(8'h00, 8'hFF, 1, 1);
        check("burst_c2", int'(code_out), 2);
        check("burst_pend0", int'(pending_out), 0);
        step(8'h00, 8'hFF, 1, 1);
        check("burst_vlow", int'(code_valid), 0);

        // 3 Backpressure
        step(8'h04, 8'hFF, 0, 1);
        step(8'h00, 8'hFF, 0, 1);
        check("bp_c2", int'(code_out), 2);
        check("bp_v", int'(code_valid), 1);
        step(8'h40, 8'hFF, 0, 1);
        step(8'h00, 8'hFF, 0, 1);
        check("bp_hold", int'(code_out), 2);
        check("bp_pend", int'(pending_out), 8'h40);
        step(8'h00, 8'hFF, 1, 1);
        check("bp_c6", int'(code_out), 6);
        check("bp_v6", int'(code_valid), 1);
        step(8'h00, 8'hFF, 1, 1);
        check("bp_drain", int'(code_valid), 0);

        // 4 Mask
        step(8'h80, 8'h7F, 1, 1);
        check("mask_nocap", int'(pending_out), 0);
        step(8'h00, 8'h7F, 1, 1);
        check("mask_novalid", int'(code_valid), 0);
        step(8'h80, 8'hFF, 0, 1);
        step(8'h00, 8'h7F, 1, 1);
        check("mask_issued", int'(code_out), 7);
        check("mask_issued_v", int'(code_valid), 1);
        step(8'h00, 8'hFF, 1, 1);

        // 5 Overrun while stalled, then same-cycle re-request
        step(8'h01, 8'hFF, 0, 1);
        step(8'h08, 8'hFF, 0, 1);
        check("ov_c0", int'(code_out), 0);
        step(8'h08, 8'hFF, 0, 1);
        check("ov_pulse", int'(overrun), 1);
        step(8'h00, 8'hFF, 0, 1);
        check("ov_once", int'(overrun), 0);
        step(8'h00, 8'hFF, 1, 1);
        check("ov_c3", int'(code_out), 3);
        check("ov_pend0", int'(pending_out), 0);
        step(8'h00, 8'hFF, 1, 1);
        check("ov_single", int'(code_valid), 0);
        step(8'h08, 8'hFF, 1, 1);
        step(8'h08, 8'hFF, 1, 1);
        check("sc_c3a", int'(code_out), 3);
        check("sc_still", int'(pending_out), 8'h08);
        check("sc_noov", int'(overrun), 0);
        step(8'h00, 8'hFF, 1, 1);
        check("sc_c3b", int'(code_out), 3);
        check("sc_v", int'(code_valid), 1);
        step(8'h00, 8'hFF, 1, 1);
        check("sc_done", int'(code_valid), 0);

        // 6 Reset mid-burst
        step(8'hFF, 8'hFF, 1, 1);
        step(8'h00, 8'hFF, 1, 1);
        check("mid_c7", int'(code_out), 7);
        step(8'h00, 8'hFF, 1, 0);
        check("mid_pend", int'(pending_out), 0);
        check("mid_valid", int'(code_valid), 0);
        check("mid_code", int'(code_out), 0);
        step(8'h00, 8'hFF, 1, 1);
        step(8'h00, 8'hFF, 1, 1);
        check("mid_quiet", int'(code_valid), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] r, m;
            logic rd, rn;
            r  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            m  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            rd = ($urandom_range(0, 2) != 0);
            rn = ($urandom_range(0, 99) != 0);
            step(r, m, rd, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
